uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive side of the UART: oversampled serial-to-parallel receiver for the frames produced by the UART TX path.
//  Frame: start(0), DATA_WIDTH data bits LSB first, optional parity bit, stop(1).
//  Detects the start edge, majority-votes 3 mid-bit samples, deserialises, and checks parity and stop bits.
//  Reports each frame as a one-cycle P_DATA/Data_Valid pulse plus error flags.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
//  PRE_WIDTH   6  width of Prescale (supported oversampling ratios 8, 16, 32)
// PORTS
//  CLK         in   1           oversampling clock (Prescale x baud)
//  RST         in   1           asynchronous, active-high reset
//  RX_IN       in   1           serial line, idle high (already synchronised upstream)
//  PAR_EN      in   1           1 = frame carries a parity bit
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  Prescale    in   PRE_WIDTH   oversampling ratio P
//  P_DATA      out  DATA_WIDTH  last good received byte (registered, held)
//  Data_Valid  out  1           one-cycle pulse: P_DATA updated, frame error-free
//  par_err     out  1           one-cycle pulse: parity mismatch on the frame just ended
//  stp_err     out  1           one-cycle pulse: stop bit sampled 0
//  Busy        out  1           high while state != IDLE
// BEHAVIOUR
//  Reset (any time, incl. mid-frame): state=IDLE, counters 0, P_DATA=0, Data_Valid=par_err=stp_err=Busy=0.
//  PAR_EN, PAR_TYP, Prescale latched on start detection; changes mid-frame are ignored.
//  Prescale values other than 8/16/32 are treated as 8. H = P/2.
//  edge_cnt counts 0..P-1 per bit period; bit_cnt counts data bits 0..DATA_WIDTH-1.
//  Sampling: RX_IN captured at edge_cnt = H-1, H, H+1; vote = majority of 3, valid from edge_cnt = H+2.
//  States:
//   IDLE   : RX_IN==0 at a CLK edge -> START, edge_cnt=0 (that edge is edge 0).
//   START  : at edge_cnt=P-1: vote==0 -> DATA; vote==1 -> IDLE (glitch, no outputs pulsed).
//   DATA   : at edge_cnt=P-1: shift vote into bit [bit_cnt] (LSB first);
//            last bit -> PARITY if PAR_EN, else STOP.
//   PARITY : at edge_cnt=P-1: record mismatch of vote vs even/odd parity of data -> STOP.
//   STOP   : at edge_cnt=H+2 (early exit for baud tolerance) -> IDLE.
//            Next edge: if no error, P_DATA<=data and Data_Valid=1;
//            else par_err/stp_err pulse as applicable, and P_DATA is unchanged.
//  Both errors may pulse together; Data_Valid is never high with an error flag.
//  Timing: Data_Valid high after edge (1+DATA_WIDTH+PAR_EN)*P + H + 3.
//   P=8, DW=8: edge 79 (no parity), edge 87 (parity).
//  Back-to-back frames: IDLE is re-entered during the stop bit. The next falling edge is detected
//   on the first CLK edge where RX_IN==0; no frame is lost with zero idle time.
//  A line held low after a stop error is treated as a new start bit.
//  Busy is combinational from the registered state only (glitch-free).
// STRUCTURE
//  Shared package uart_pkg: RX state encoding (IDLE, START, DATA, PARITY, STOP),
//   legal prescale constants (8/16/32), parity-type constants.
//  Sub-module uart_rx_sampler: edge counter + 3-sample capture + majority vote;
//   outputs edge_cnt and vote.
//  Top level holds the FSM, bit counter, shift register, parity/stop checks and output registers.
// TESTING
//  1. P=8, PAR_EN=0, send 0xA5 -> P_DATA=0xA5, Data_Valid 1 cycle at edge 79, no errors.
//  2. P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> P_DATA=0x3C, Data_Valid; then parity 1 -> par_err pulse, P_DATA stays 0x3C.
//  3. P=32, odd parity, stop bit 0 on 0x81 -> stp_err pulse, no Data_Valid; line held low -> next frame decoded normally.
//  4. 2-cycle low glitch on RX_IN in IDLE (P=8) -> returns to IDLE, no output pulses, Busy high only during glitch frame.
//  5. Two frames 0x55, 0xAA back-to-back with zero idle -> two Data_Valid pulses with P_DATA 0x55 then 0xAA.
//  6. RST asserted during DATA bit 4 -> all outputs 0 immediately; clean frame 0x0F afterwards received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, legal prescale ratios and parity-type constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
    localparam int PRE_8  = 8;
    localparam int PRE_16 = 16;
    localparam int PRE_32 = 32;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    // Any unsupported oversampling ratio falls back to 8
    function automatic int legal_pre(input int p);
        return (p == PRE_16 || p == PRE_32) ? p : PRE_8;
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with 3-sample mid-bit capture and majority vote
//   clk, rst    : oversampling clock, async active-high reset
//   run_i       : counter runs while the receiver is not idle, held at 0 otherwise
//   rx_i        : serial line
//   pre_i       : latched oversampling ratio P
//   edge_cnt_o  : position 0..P-1 inside the current bit period
//   vote_o      : majority of the samples at H-1, H, H+1 (valid from H+2)
module uart_rx_sampler #(
    parameter int PRE_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic                 rx_i,
    input  logic [PRE_WIDTH-1:0] pre_i,
    output logic [PRE_WIDTH-1:0] edge_cnt_o,
    output logic                 vote_o
);
    localparam logic [PRE_WIDTH-1:0] ONE = PRE_WIDTH'(1);
    logic [PRE_WIDTH-1:0] cnt_q, cnt_d, half;
    logic [2:0] smp_q, smp_d;
    always_comb begin
        half     = pre_i >> 1;
        cnt_d    = (!run_i || cnt_q == pre_i - ONE) ? '0 : cnt_q + ONE;
        smp_d[0] = (cnt_q == half - ONE) ? rx_i : smp_q[0];
        smp_d[1] = (cnt_q == half) ? rx_i : smp_q[1];
        smp_d[2] = (cnt_q == half + ONE) ? rx_i : smp_q[2];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end
    assign edge_cnt_o = cnt_q;
    assign vote_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver with parity and stop-bit checking
//   CLK, RST    : oversampling clock (Prescale x baud), async active-high reset
//   RX_IN       : serial line, idle high
//   PAR_EN      : frame carries a parity bit
//   PAR_TYP     : 0 even, 1 odd parity
//   Prescale    : oversampling ratio (8/16/32, anything else means 8)
//   P_DATA      : last error-free byte, held
//   Data_Valid  : one-cycle pulse when P_DATA is updated
//   par_err     : one-cycle pulse on parity mismatch
//   stp_err     : one-cycle pulse when the stop bit is sampled low
//   Busy        : receiver not idle
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRE_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRE_WIDTH-1:0]  Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  Busy
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRE_WIDTH-1:0] ONE = PRE_WIDTH'(1);
    localparam logic [PRE_WIDTH-1:0] TWO = PRE_WIDTH'(2);
    rx_state_e state_q, state_d;
    logic [PRE_WIDTH-1:0] pre_q, edge_cnt, half;
    logic [DATA_WIDTH-1:0] data_q, p_data_q, p_data_d;
    logic [BW-1:0] bit_cnt_q;
    logic par_en_q, par_typ_q, par_bad_q;
    logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic vote, bit_end, stop_end, last_bit, start_det, frame_end;
    uart_rx_sampler #(.PRE_WIDTH(PRE_WIDTH)) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .run_i      (Busy),
        .rx_i       (RX_IN),
        .pre_i      (pre_q),
        .edge_cnt_o (edge_cnt),
        .vote_o     (vote)
    );
    assign half      = pre_q >> 1;
    assign bit_end   = edge_cnt == pre_q - ONE;
    // Leave the stop bit as soon as its vote is ready so the next start edge is not missed
    assign stop_end  = edge_cnt == half + TWO;
    assign last_bit  = bit_cnt_q == BW'(DATA_WIDTH - 1);
    assign start_det = state_q == IDLE && !RX_IN;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN) state_d = START;
            START:   if (bit_end) state_d = vote ? IDLE : DATA;
            DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (stop_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        Busy      = state_q != IDLE;
        frame_end = state_q == STOP && stop_end;
        dv_d      = frame_end && vote && !par_bad_q;
        pe_d      = frame_end && par_bad_q;
        se_d      = frame_end && !vote;
        p_data_d  = dv_d ? data_q : p_data_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q     <= PRE_WIDTH'(PRE_8);
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            par_bad_q <= 1'b0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            se_q     <= se_d;
            p_data_q <= p_data_d;
            if (start_det) begin
                pre_q     <= PRE_WIDTH'(legal_pre(int'(Prescale)));
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_bad_q <= 1'b0;
                bit_cnt_q <= '0;
            end
            if (state_q == DATA && bit_end) begin
                data_q[bit_cnt_q] <= vote;
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (state_q == PARITY && bit_end)
                par_bad_q <= vote != (^data_q ^ (par_typ_q == PAR_ODD));
        end
    end
    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: frame-level reference model over a prebuilt line waveform, checked every cycle
module tb_uart_rx_ctrl;
    localparam int N = 16000;
    logic CLK = 1'b0;
    logic RST, RX_IN, PAR_EN, PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic Data_Valid, par_err, stp_err, Busy;

    // Stimulus, indexed by interval k = time between clock edge k and edge k+1
    bit line [N];
    bit pen [N];
    bit ptyp [N];
    bit rst_a [N];
    logic [5:0] pre [N];
    // Expected outputs observed in interval k
    bit exp_busy [N];
    bit exp_dv [N];
    bit exp_pe [N];
    bit exp_se [N];
    logic [7:0] exp_byte [N];
    logic [7:0] exp_pd [N];

    int t, T, cyc, errors, checks;
    bit running;
    bit cur_pe, cur_pt;
    logic [5:0] cur_pre;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, k, got, want);
        end
    endtask

    function automatic int legal(input int p);
        return (p == 16 || p == 32) ? p : 8;
    endfunction

    // Majority of the line as seen at clock edges e, e+1, e+2
    function automatic bit maj(input int e);
        return (int'(line[e-1]) + int'(line[e]) + int'(line[e+1])) >= 2;
    endfunction

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            line[t] = v; pen[t] = cur_pe; ptyp[t] = cur_pt; pre[t] = cur_pre; rst_a[t] = 1'b0;
            t++;
        end
    endtask

    task automatic do_rst(input int n);
        for (int i = 0; i < n; i++) begin
            line[t] = 1'b1; pen[t] = cur_pe; ptyp[t] = cur_pt; pre[t] = cur_pre; rst_a[t] = 1'b1;
            t++;
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic [5:0] praw, input bit pe, input bit pt,
                         input bit bad_par, input bit stop_v, input bit scr, output int t0);
        int p;
        p = legal(int'(praw));
        t0 = t;
        cur_pre = praw; cur_pe = pe; cur_pt = pt;
        put(1'b0, p);
        for (int j = 0; j < 8; j++) begin
            if (scr) begin
                cur_pe = 1'($urandom); cur_pt = 1'($urandom); cur_pre = 6'($urandom);
            end
            put(d[j], p);
        end
        cur_pre = praw; cur_pe = pe; cur_pt = pt;
        if (pe) put(^d ^ pt ^ bad_par, p);
        put(stop_v, p);
    endtask

    task automatic run_model();
        int e, e0, p, h, x, r;
        bit pe, pt, pm, vs, gl;
        logic [7:0] d, pd;
        e = 1;
        while (e < T) begin
            if (rst_a[e-1] || line[e-1]) begin
                e++;
                continue;
            end
            e0 = e;
            p = legal(int'(pre[e0-1]));
            h = p / 2;
            pe = pen[e0-1];
            pt = ptyp[e0-1];
            gl = maj(e0 + h);
            d = '0; pm = 1'b0; vs = 1'b1;
            if (gl) x = e0 + p;
            else begin
                for (int j = 0; j < 8; j++) d[j] = maj(e0 + (j + 1) * p + h);
                pm = pe && (maj(e0 + 9 * p + h) != (^d ^ pt));
                vs = maj(e0 + (9 + int'(pe)) * p + h);
                x = e0 + (9 + int'(pe)) * p + h + 3;
            end
            r = -1;
            for (int k = x; k >= e0; k--) if (rst_a[k]) r = k;
            if (r >= 0) begin
                for (int k = e0; k < r; k++) exp_busy[k] = 1'b1;
                e = r + 1;
            end else begin
                for (int k = e0; k < x; k++) exp_busy[k] = 1'b1;
                if (!gl) begin
                    exp_dv[x] = !pm && vs;
                    exp_pe[x] = pm;
                    exp_se[x] = !vs;
                    exp_byte[x] = d;
                end
                e = x + 1;
            end
        end
        pd = '0;
        for (int k = 0; k < N; k++) begin
            if (rst_a[k]) pd = '0;
            else if (exp_dv[k]) pd = exp_byte[k];
            exp_pd[k] = pd;
        end
    endtask

    always @(negedge CLK) begin
        if (running && cyc < T) begin
            chk("busy", cyc, 8'(Busy), 8'(exp_busy[cyc]));
            chk("data_valid", cyc, 8'(Data_Valid), 8'(exp_dv[cyc]));
            chk("par_err", cyc, 8'(par_err), 8'(exp_pe[cyc]));
            chk("stp_err", cyc, 8'(stp_err), 8'(exp_se[cyc]));
            chk("p_data", cyc, P_DATA, exp_pd[cyc]);
        end
    end

    initial begin
        int t1, t2a, t2b, t3a, t3b, t4, t5a, t5b, t6, t6b, r, tx;
        int gap, sel;
        logic [5:0] praw;
        errors = 0; checks = 0; cyc = 0; t = 0; running = 1'b0;
        for (int k = 0; k < N; k++) begin
            line[k] = 1'b1; pre[k] = 6'd8;
        end
        cur_pe = 1'b0; cur_pt = 1'b0; cur_pre = 6'd8;
        do_rst(3);
        put(1'b1, 5);
        frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t1);
        put(1'b1, 10);
        frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, t2a);
        put(1'b1, 5);
        frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t2b);
        put(1'b1, 10);
        frame(8'h81, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t3a);
        frame(8'h5A, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, t3b);
        put(1'b1, 10);
        cur_pre = 6'd8; cur_pe = 1'b0;
        t4 = t;
        put(1'b0, 2);
        put(1'b1, 20);
        frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t5a);
        frame(8'hAA, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t5b);
        put(1'b1, 10);
        frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t6);
        r = t6 + 43;
        for (int k = r; k < t; k++) line[k] = 1'b1;
        for (int k = r; k < r + 3; k++) rst_a[k] = 1'b1;
        put(1'b1, 10);
        frame(8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t6b);
        put(1'b1, 10);
        for (int i = 0; i < 25; i++) begin
            sel = int'($urandom_range(0, 3));
            praw = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32 : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) begin
                put(1'b0, int'($urandom_range(1, 3)));
                put(1'b1, 40);
            end
            frame(8'($urandom), praw, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) != 0, 1'b1, tx);
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            put(1'b1, gap);
        end
        put(1'b1, 60);
        T = t;
        run_model();

        chk("pin_t1_dv_at_79", t1 + 80, 8'(exp_dv[t1 + 80]), 8'd1);
        chk("pin_t1_no_dv_at_78", t1 + 79, 8'(exp_dv[t1 + 79]), 8'd0);
        chk("pin_t1_pdata", t1 + 80, exp_pd[t1 + 80], 8'hA5);
        chk("pin_t1_busy_start", t1 + 1, 8'(exp_busy[t1 + 1]), 8'd1);
        chk("pin_t2_dv", t2a + 172, 8'(exp_dv[t2a + 172]), 8'd1);
        chk("pin_t2_pdata", t2a + 172, exp_pd[t2a + 172], 8'h3C);
        chk("pin_t2_par_err", t2b + 172, 8'(exp_pe[t2b + 172]), 8'd1);
        chk("pin_t2_no_dv", t2b + 172, 8'(exp_dv[t2b + 172]), 8'd0);
        chk("pin_t2_pdata_held", t2b + 172, exp_pd[t2b + 172], 8'h3C);
        chk("pin_t3_stp_err", t3a + 340, 8'(exp_se[t3a + 340]), 8'd1);
        chk("pin_t3_no_dv", t3a + 340, 8'(exp_dv[t3a + 340]), 8'd0);
        chk("pin_t3_next_dv", t3a + 680, 8'(exp_dv[t3a + 680]), 8'd1);
        chk("pin_t3_next_pdata", t3a + 680, exp_pd[t3a + 680], 8'h5A);
        chk("pin_t4_busy_first", t4 + 1, 8'(exp_busy[t4 + 1]), 8'd1);
        chk("pin_t4_busy_last", t4 + 8, 8'(exp_busy[t4 + 8]), 8'd1);
        chk("pin_t4_idle_after", t4 + 9, 8'(exp_busy[t4 + 9]), 8'd0);
        chk("pin_t5_first", t5a + 80, exp_pd[t5a + 80], 8'h55);
        chk("pin_t5_second_dv", t5b + 80, 8'(exp_dv[t5b + 80]), 8'd1);
        chk("pin_t5_second", t5b + 80, exp_pd[t5b + 80], 8'hAA);
        chk("pin_t6_busy_before_rst", r - 1, 8'(exp_busy[r - 1]), 8'd1);
        chk("pin_t6_pdata_rst", r, exp_pd[r], 8'h00);
        chk("pin_t6_clean", t6b + 80, exp_pd[t6b + 80], 8'h0F);

        RST = rst_a[0]; RX_IN = line[0]; PAR_EN = pen[0]; PAR_TYP = ptyp[0]; Prescale = pre[0];
        running = 1'b1;
        for (int k = 1; k < T; k++) begin
            @(posedge CLK);
            #1;
            RST = rst_a[k]; RX_IN = line[k]; PAR_EN = pen[k]; PAR_TYP = ptyp[k]; Prescale = pre[k];
        end
        repeat (2) @(posedge CLK);
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
